// File: rtl/filter_pkg.sv
// Shared encodings and constants for the streaming 3x3 neighbourhood filter.
package filter_pkg;

  localparam logic [1:0] MODE_PASS  = 2'd0;
  localparam logic [1:0] MODE_BOX   = 2'd1;
  localparam logic [1:0] MODE_GAUSS = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // Indexed [row][col]; the weights total 16, hence the shift of 4.
  localparam int GAUSS_K [3][3] = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};
  localparam int GAUSS_SHIFT = 4;

  // 9 * (2^PIX_W - 1) and 16 * (2^PIX_W - 1) both fit in PIX_W+4 bits.
  function automatic int sum_w(input int pix_w);
    return pix_w + 4;
  endfunction

endpackage

// File: rtl/stream_filter_3x3_if.sv
// Input and output pixel streams of the 3x3 filter; slave is the filter side.
interface stream_filter_3x3_if #(parameter int PIX_W = 8);
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_data;
  logic             out_last;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_last);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/line_buffer.sv
// One-row delay line: dout is the sample written DEPTH enabled cycles earlier.
module line_buffer #(
  parameter int PIX_W = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PIX_W-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;

  // Read-before-write at the same slot gives the DEPTH-step delay.
  assign dout = mem[ptr];

  always_ff @(posedge clk)
    if (en) mem[ptr] <= din;

  always_ff @(posedge clk or posedge rst)
    if (rst)     ptr <= '0;
    else if (en) ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;

endmodule

// File: rtl/stream_filter_3x3.sv
// Streaming 3x3 pass/box/Gaussian filter; borders pass through unchanged.
module stream_filter_3x3
  import filter_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                mode,
  stream_filter_3x3_if.slave        s,
  output logic                      busy,
  output logic                      frame_done
);
  localparam int SW = sum_w(PIX_W);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam int FW = $clog2(IMG_W + 1);

  state_t           state, state_nx;
  logic             rdy_en, in_ready, acc, step, emit, adv, out_hs;
  logic             in_last, flush_end, border;
  logic [RW-1:0]    in_row, out_row;
  logic [CW-1:0]    in_col, out_col;
  logic [FW-1:0]    flush_cnt;
  logic [1:0]       mode_q;
  logic [PIX_W-1:0] pix, res;
  logic [PIX_W-1:0] tap [3];
  logic [1:0][2:0][PIX_W-1:0] win;   // [col][row], col 0 oldest
  logic [2:0][2:0][PIX_W-1:0] wc;
  logic [SW-1:0]    box, gss;
  logic             out_valid, out_last;
  logic [PIX_W-1:0] out_data;

  assign s.in_ready  = in_ready;
  assign s.out_valid = out_valid;
  assign s.out_data  = out_data;
  assign s.out_last  = out_last;

  assign adv       = !out_valid || s.out_ready;
  assign out_hs    = out_valid && s.out_ready;
  assign acc       = s.in_valid && in_ready;
  assign in_last   = (in_row == RW'(IMG_H - 1)) && (in_col == CW'(IMG_W - 1));
  assign flush_end = (flush_cnt == FW'(IMG_W));

  // Two cascaded row delays: tap[1] is row r-1, tap[2] is row r-2.
  assign tap[0] = pix;
  for (genvar i = 0; i < 2; i++) begin : g_lb
    line_buffer #(.PIX_W(PIX_W), .DEPTH(IMG_W)) u_lb (
      .clk(clk), .rst(rst), .en(step), .din(tap[i]), .dout(tap[i+1])
    );
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else     state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (acc)                  state_nx = S_RUN;
      S_RUN:   if (acc && in_last)       state_nx = S_FLUSH;
      S_FLUSH: if (adv && flush_end)     state_nx = S_DRAIN;
      S_DRAIN: if (out_hs && out_last)   state_nx = S_IDLE;
      default:                           state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    step     = 1'b0;
    pix      = s.in_data;
    case (state)
      S_IDLE, S_RUN: begin
        in_ready = rdy_en && adv;
        step     = s.in_valid && in_ready;
      end
      S_FLUSH: begin
        step = adv;
        pix  = '0;
      end
      default: ;
    endcase
    // Output k appears once raster step k+IMG_W+1 has happened.
    emit = step && (state == S_FLUSH || in_row >= RW'(2) ||
                    (in_row == RW'(1) && in_col != '0));
    busy = (state != S_IDLE);
  end

  assign wc[0] = win[0];
  assign wc[1] = win[1];
  assign wc[2] = {tap[0], tap[1], tap[2]};

  always_comb begin
    box = '0;
    gss = '0;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++) begin
        box += SW'(wc[c][r]);
        gss += SW'(wc[c][r]) * SW'(GAUSS_K[r][c]);
      end
    border = (out_row == '0) || (out_row == RW'(IMG_H - 1)) ||
             (out_col == '0) || (out_col == CW'(IMG_W - 1));
    case (mode_q)
      MODE_BOX:   res = PIX_W'(box / SW'(9));
      MODE_GAUSS: res = PIX_W'(gss >> GAUSS_SHIFT);
      default:    res = wc[1][1];
    endcase
    if (border) res = wc[1][1];
  end

  always_ff @(posedge clk)
    if (step) win <= {wc[2], wc[1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en     <= 1'b0;
      mode_q     <= MODE_PASS;
      in_row     <= '0;
      in_col     <= '0;
      out_row    <= '0;
      out_col    <= '0;
      flush_cnt  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      rdy_en     <= 1'b1;
      frame_done <= (state == S_DRAIN) && out_hs && out_last;
      if (state == S_IDLE && acc) mode_q <= mode;
      if (acc) begin
        if (in_col == CW'(IMG_W - 1)) begin
          in_col <= '0;
          in_row <= in_last ? '0 : in_row + 1'b1;
        end else begin
          in_col <= in_col + 1'b1;
        end
      end
      if (state == S_FLUSH && step)
        flush_cnt <= flush_end ? '0 : flush_cnt + 1'b1;
      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= res;
        out_last  <= (out_row == RW'(IMG_H - 1)) && (out_col == CW'(IMG_W - 1));
        if (out_col == CW'(IMG_W - 1)) begin
          out_col <= '0;
          out_row <= (out_row == RW'(IMG_H - 1)) ? '0 : out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end else if (s.out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_filter_3x3.sv
// Directed-plus-random bench for stream_filter_3x3 against an image-level model.
module tb_stream_filter_3x3;
  localparam int W = 16;
  localparam int H = 16;
  localparam int NPIX = W * H;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic       busy, frame_done;

  stream_filter_3x3_if #(.PIX_W(8)) sif();

  stream_filter_3x3 #(.PIX_W(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .mode(mode), .s(sif),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  logic [7:0] src[$];
  logic [1:0] fmode[$];
  logic [7:0] got[$];
  bit         lastf[$];
  int         fd_cnt, stall_viol;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Image-level reference: borders copy, interior is a 3x3 weighted mean.
  function automatic logic [7:0] model_px(input int f, input int r, input int c);
    int base = f * NPIX;
    int s = 0;
    logic [1:0] md = fmode[f];
    if (r == 0 || r == H-1 || c == 0 || c == W-1 || md == 2'd0 || md == 2'd3)
      return src[base + r*W + c];
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        int p = int'(src[base + (r+dr)*W + c + dc]);
        s += (md == 2'd1) ? p : p * (dr == 0 ? 2 : 1) * (dc == 0 ? 2 : 1);
      end
    return (md == 2'd1) ? 8'(s / 9) : 8'(s / 16);
  endfunction

  task automatic run(input bit stalls, input bit gaps);
    int idx = 0;
    int nout = 0;
    int cyc = 0;
    int n_in = src.size();
    bit hs_in, hs_out;
    got.delete(); lastf.delete();
    fd_cnt = 0; stall_viol = 0;
    while (nout < n_in && cyc < 20000) begin
      sif.out_ready = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
      if (idx < n_in) begin
        sif.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        sif.in_data  = src[idx];
        mode = (idx % NPIX == 0) ? fmode[idx / NPIX] : 2'($urandom);
      end else begin
        sif.in_valid = 1'b0;
      end
      @(negedge clk);
      hs_in  = sif.in_valid && sif.in_ready;
      hs_out = sif.out_valid && sif.out_ready;
      if (sif.out_valid && !sif.out_ready && sif.in_ready) stall_viol++;
      if (hs_out) begin
        got.push_back(sif.out_data);
        lastf.push_back(sif.out_last);
        nout++;
      end
      if (frame_done) fd_cnt++;
      @(posedge clk); #1;
      if (hs_in) idx++;
      cyc++;
    end
    sif.in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
    end
    @(posedge clk); #1;
    check("out_count", nout, n_in);
    check("in_count", idx, n_in);
    check("stall_in_ready", stall_viol, 0);
  endtask

  task automatic verify(input string tag);
    int lastbad = 0;
    for (int k = 0; k < src.size(); k++) begin
      logic [31:0] g = (k < got.size()) ? 32'(got[k]) : 32'hFFFF_FFFF;
      check($sformatf("%s_px%0d", tag, k), g,
            32'(model_px(k / NPIX, (k % NPIX) / W, k % W)));
      if (k < lastf.size() && lastf[k] != (k % NPIX == NPIX - 1)) lastbad++;
    end
    check({tag, "_out_last"}, lastbad, 0);
  endtask

  initial begin
    int n, cyc;
    rst = 1'b1; mode = 2'd0;
    sif.in_valid = 1'b0; sif.in_data = '0; sif.out_ready = 1'b1;
    #2;
    check("rst_in_ready", sif.in_ready, 0);
    check("rst_out_valid", sif.out_valid, 0);
    check("rst_out_data", sif.out_data, 0);
    check("rst_out_last", sif.out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", sif.in_ready, 1);

    // Constant frame, box mode, no backpressure
    src.delete(); repeat (NPIX) src.push_back(8'd100);
    fmode = '{2'd1};
    run(1'b0, 1'b0);
    verify("const100");
    check("const100_fd", fd_cnt, 1);
    check("const100_busy_after", busy, 0);

    // Impulse, box then Gaussian
    src.delete(); repeat (NPIX) src.push_back(8'd0);
    src[5*W + 5] = 8'd255;
    fmode = '{2'd1};
    run(1'b0, 1'b0);
    verify("imp_box");
    check("imp_box_c", got[5*W+5], 28);
    check("imp_box_44", got[4*W+4], 28);
    check("imp_box_66", got[6*W+6], 28);
    check("imp_box_37", got[3*W+7], 0);
    fmode = '{2'd2};
    run(1'b0, 1'b0);
    verify("imp_gauss");
    check("imp_gauss_c", got[5*W+5], 63);
    check("imp_gauss_edge", got[4*W+5], 31);
    check("imp_gauss_edge2", got[5*W+6], 31);
    check("imp_gauss_corner", got[6*W+4], 15);
    check("imp_gauss_far", got[7*W+5], 0);

    // Column ramp with output stalls and input gaps
    src.delete();
    for (int i = 0; i < NPIX; i++) src.push_back(8'(i % W));
    fmode = '{2'd1};
    run(1'b1, 1'b1);
    verify("ramp_stall");
    check("ramp_fd", fd_cnt, 1);

    // Two random frames back-to-back, mode churn mid-frame
    src.delete();
    for (int i = 0; i < 2*NPIX; i++) src.push_back(8'($urandom));
    fmode = '{2'd2, 2'd1};
    run(1'b1, 1'b0);
    verify("b2b");
    check("b2b_fd", fd_cnt, 2);
    check("b2b_busy_after", busy, 0);

    // Abort a frame with reset after 100 inputs
    n = 0; cyc = 0; mode = 2'd1; sif.out_ready = 1'b1;
    while (n < 100 && cyc < 1000) begin
      sif.in_valid = 1'b1; sif.in_data = 8'($urandom);
      @(negedge clk);
      if (sif.in_ready) n++;
      @(posedge clk); #1;
      cyc++;
    end
    check("partial_fed", n, 100);
    check("partial_busy", busy, 1);
    sif.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_out_valid", sif.out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", sif.in_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    src.delete(); repeat (NPIX) src.push_back(8'd50);
    fmode = '{2'd1};
    run(1'b0, 1'b1);
    verify("after_rst");
    check("after_rst_fd", fd_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
